// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: computes the low WIDTH bits of an unsigned product by
// stepping the shared single-cycle ALU through add / shift-left / shift-right
// iterations. The ALU is driven combinationally from the current state and
// registers, and its result is consumed in the same cycle.
//
// Handshake: start is sampled only in IDLE; no valid/ready back-pressure
// exists. busy is high while iterating, done pulses for exactly one cycle,
// and product is valid from the done cycle until the next done.
module alu_mul_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_operand_a,
    output logic [WIDTH-1:0] alu_operand_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] product_q;
    logic             busy_q;
    logic             done_q;

    // The zero flag is reserved for a later shortcut; it is not consumed yet.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    // Operand/op selection for the shared ALU; idle values outside the loop.
    always_comb begin
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_op        = OP_ADD;
        case (state_q)
            S_ADD: begin
                alu_operand_a = acc_q;
                alu_operand_b = mcand_q;
                alu_op        = OP_ADD;
            end
            S_SHL: begin
                alu_operand_a = mcand_q;
                alu_operand_b = WIDTH'(1);
                alu_op        = OP_SLL;
            end
            S_SHR: begin
                alu_operand_a = mplier_q;
                alu_operand_b = WIDTH'(1);
                alu_op        = OP_SRL;
            end
            default: begin
                alu_operand_a = '0;
                alu_operand_b = '0;
                alu_op        = OP_ADD;
            end
        endcase
    end

    // Shift-add sequencer with registered busy/done/product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= mul_a;
                        mplier_q <= mul_b;
                        count_q  <= '0;
                        if (mul_b == '0) begin
                            // Nothing to accumulate: the product is the fresh zero accumulator.
                            state_q   <= S_DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            product_q <= '0;
                        end else begin
                            state_q <= S_ADD;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_ADD: begin
                    if (mplier_q[0]) begin
                        acc_q <= alu_result;
                    end
                    state_q <= S_SHL;
                end
                S_SHL: begin
                    mcand_q <= alu_result;
                    state_q <= S_SHR;
                end
                S_SHR: begin
                    mplier_q <= alu_result;
                    count_q  <= count_q + CW'(1);
                    if ((EARLY_EXIT && (alu_result == '0)) || (count_q == LAST_ITER)) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= acc_q;
                    end else begin
                        state_q <= S_ADD;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
